mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, shared RAM word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter STARVE_MAX, default 3, consecutive denied fetch cycles before the fetch port is forced to win.
REQ-004 clk  in  1  single clock; every register updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_req  in  1  fetch read request; i_addr  in  ADDR_W  fetch word address.
REQ-007 i_gnt  out  1  fetch request accepted this cycle; i_rvalid  out  1  fetch read data valid; i_rdata  out  DATA_W  fetch read data.
REQ-008 d_req  in  1  data-stage request; d_we  in  1  write (1) or read (0); d_addr  in  ADDR_W; d_wdata  in  DATA_W.
REQ-009 d_gnt  out  1  data request accepted; d_rvalid  out  1  data read valid; d_rdata  out  DATA_W  data read data.
REQ-010 ram_addr  out  ADDR_W; ram_wdata  out  DATA_W; ram_wren  out  1; ram_q  in  DATA_W  to the single-port synchronous RAM, read latency 1.

Function
REQ-011 i_gnt and d_gnt are combinational in the request cycle; at most one is high per cycle.
REQ-012 Default priority: d_req wins whenever both ports request.
REQ-013 starve_cnt (clog2(STARVE_MAX+1) bits) increments when i_req=1 and i_gnt=0, clears when i_gnt=1 or i_req=0, saturates at STARVE_MAX.
REQ-014 When starve_cnt==STARVE_MAX and i_req=1, i_gnt=1 and d_gnt=0 that cycle, even if d_req=1.
REQ-015 The granted port drives ram_addr; ram_wren = d_gnt & d_we; ram_wdata = d_wdata whenever d_gnt=1; with no grant, ram_wren=0 and ram_addr holds its last driven value.
REQ-016 A requester that is not granted holds its request stable until granted; the arbiter does not queue requests.
REQ-017 The FSM state records the access issued in the previous cycle: IDLE (no grant), RD_I (fetch read), RD_D (data read), WR_D (data write).
REQ-018 The next state is set from this cycle's grant: i_gnt -> RD_I; d_gnt&~d_we -> RD_D; d_gnt&d_we -> WR_D; otherwise IDLE.
REQ-019 i_rvalid=1 exactly in state RD_I, and d_rvalid=1 exactly in state RD_D; each is high for one cycle per granted read.
REQ-020 i_rdata and d_rdata both present ram_q; read latency is exactly 1 cycle after the grant.
REQ-021 Writes produce no rvalid; state WR_D only records that a write was issued.
REQ-022 Back-to-back grants to either port are legal every cycle, giving a throughput of one access per cycle.
REQ-023 A data read that immediately follows a write to the same address returns the newly written data.

Reset
REQ-024 While rst=1: i_gnt=0, d_gnt=0, ram_wren=0, i_rvalid=0, d_rvalid=0, state=IDLE, starve_cnt=0, ram_addr=0.
REQ-025 A read granted in the cycle before rst asserts produces no rvalid.
REQ-026 In the first cycle after rst deasserts, both rvalid outputs are 0 and arbitration restarts with starve_cnt=0.

Structure
REQ-027 The shared package holds the FSM state enum (IDLE, RD_I, RD_D, WR_D) and the default values of ADDR_W, DATA_W and STARVE_MAX.
REQ-028 The starvation counter is the one natural sub-module, mem_arb_starve_cnt; everything else stays in mem_port_arbiter.
REQ-029 The RAM is external to this block; the block contains no storage array.

Verification
REQ-030 Scenario: i_req=1 with i_addr=5 alone, and ram_q=0xDEADBEEF in the next cycle -> i_gnt=1 in cycle 0; in cycle 1, i_rvalid=1, i_rdata=0xDEADBEEF, d_rvalid=0.
REQ-031 Scenario: i_req and d_req (read, addr 9) both held for 6 cycles -> d_gnt in cycles 0-2, i_gnt in cycle 3, d_gnt in cycles 4-5; no cycle has both grants.
REQ-032 Scenario: d write of 0x12345678 to addr 2, then a d read of addr 2 -> ram_wren=1 only in the write cycle; d_rvalid=1 with d_rdata=0x12345678 two cycles after the write.
REQ-033 Scenario: fetch read granted, then rst=1 for one cycle -> i_rvalid=0 in the reset cycle and in the following cycle; all outputs hold their REQ-024 values during reset.
REQ-034 Scenario: fetch reads alternating with data reads every cycle for 8 cycles -> each rvalid follows its own grant by exactly one cycle; the total is 8 rvalid pulses with no misrouting.
REQ-035 Scenario: i_req=1 for 2 cycles while d_req=1, then i_req drops -> starve_cnt reaches 2, then returns to 0; no forced grant occurs.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths and the
// state encoding that records which access was issued in the previous cycle.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF     = 6;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2,
    WR_D = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive cycles in which the fetch port asked for the RAM and was
// refused; saturates at STARVE_MAX so the arbiter can force a fetch grant.
module mem_arb_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             gnt_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_max_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: grow on a refused request, hold at the ceiling, clear otherwise.
  always_comb begin
    cnt_d = '0;
    if (req_i && !gnt_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port synchronous RAM
// (read latency 1). Data wins by default; a fetch refused STARVE_MAX times in a
// row is forced through. The state register remembers the previous cycle's
// access so read data can be steered to the right port one cycle later.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve_max;
  logic              force_i;

  mem_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .req_i    (i_req),
    .gnt_i    (i_gnt),
    .cnt_o    (starve_cnt),
    .at_max_o (starve_max)
  );

  // A starved fetch overrides the data port's default priority; no grants in reset.
  assign force_i = i_req & starve_max;
  assign i_gnt   = ~rst & i_req & (force_i | ~d_req);
  assign d_gnt   = ~rst & d_req & ~force_i;

  // RAM address follows the granted port and otherwise holds its last value.
  always_comb begin
    addr_d = addr_q;
    if (rst)        addr_d = '0;
    else if (i_gnt) addr_d = i_addr;
    else if (d_gnt) addr_d = d_addr;
  end

  // Remember the last driven address so idle cycles keep it stable.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign ram_addr  = addr_d;
  assign ram_wdata = d_wdata;
  assign ram_wren  = d_gnt & d_we;

  // Next state encodes the access issued in this cycle.
  always_comb begin
    state_d = IDLE;
    if (i_gnt)                state_d = RD_I;
    else if (d_gnt && !d_we)  state_d = RD_D;
    else if (d_gnt && d_we)   state_d = WR_D;
  end

  // State register; reset discards any read issued just before it.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Read data returns one cycle after the grant; steer the valid by state.
  assign i_rvalid = ~rst & (state_q == RD_I);
  assign d_rvalid = ~rst & (state_q == RD_D);
  assign i_rdata  = ram_q;
  assign d_rdata  = ram_q;

endmodule
